// File: rtl/out_buf_reader.sv
// Output-buffer reader: streams len words from base_addr out of the result SRAM.
// Latency: start -> buf_rd_en 1 cycle, start -> out_valid 2 cycles (fall-through skid FIFO).
// Backpressure: out_ready low stalls the stream; read credit caps FIFO + in-flight at 2 words.
// Optional OUT_BUF_CLEAR_EN: zero each word in the buffer on the data-return cycle.
`timescale 1ns/1ps
module out_buf_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   out_idx;
  logic              rd_inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              fifo_empty;
  logic              pop;
  logic              pop_fifo;
  logic              push;
  logic              rd_issue;
  logic              last_hs;
  logic              start_acc;
  logic [2:0]        occ_after;

  // Stream side: the FIFO falls through so returning data is visible in its return cycle.
  always_comb begin
    fifo_empty = (fifo_count == 2'd0);
    out_valid  = ~fifo_empty | rd_inflight;
    out_data   = '0;
    if (!fifo_empty)
      out_data = fifo_mem[rd_ptr];
    else if (rd_inflight)
      out_data = buf_rd_data;
    pop       = out_valid & out_ready;
    pop_fifo  = pop & ~fifo_empty;
    // Returning data is stored unless it bypasses straight out to an empty FIFO.
    push      = rd_inflight & ~(fifo_empty & out_ready);
    out_last  = out_valid & (out_idx == len_r - ONE);
    last_hs   = pop & out_last;
    // Occupancy after this cycle's pop must leave room for one more word.
    occ_after = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
    rd_issue  = (state == RUN) & (occ_after < 3'd2);
    start_acc = (state == IDLE) & start;
    busy      = (state != IDLE);
    done      = (state == DONE);
    buf_rd_en   = rd_issue;
    buf_rd_addr = rd_addr;
  end

  // Control FSM: sequences reads, waits for the final handshake, then pulses done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_left <= '0;
      len_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= base_addr;
            rd_left <= len;
            len_r   <= len;
            state   <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_issue) begin
            rd_addr <= rd_addr + 1'b1;
            rd_left <= rd_left - ONE;
            if (rd_left == ONE) state <= FLUSH;
          end
        end
        FLUSH:   if (last_hs) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: read-return tracking, skid FIFO storage and output word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_inflight <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      out_idx     <= '0;
    end else begin
      rd_inflight <= rd_issue;
      if (push) begin
        fifo_mem[wr_ptr] <= buf_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_fifo};
      if (start_acc)
        out_idx <= '0;
      else if (pop)
        out_idx <= out_idx + ONE;
    end
  end

`ifdef OUT_BUF_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;

  // Remember the address just read so it can be zeroed on the data-return cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clr_addr <= '0;
    else if (rd_issue)
      clr_addr <= rd_addr;
  end

  assign buf_wr_en   = rd_inflight;
  assign buf_wr_addr = clr_addr;
  assign buf_wr_data = '0;
`else
  assign buf_wr_en   = 1'b0;
  assign buf_wr_addr = '0;
  assign buf_wr_data = '0;
`endif

endmodule

// File: tb/tb_out_buf_reader.sv
// Bench for out_buf_reader: directed drains, scoreboarded stream and read addresses.
`timescale 1ns/1ps
module tb_out_buf_reader;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, buf_rd_en, buf_wr_en, out_valid, out_ready, out_last;
  logic [AW-1:0] buf_rd_addr, buf_wr_addr;
  logic [DW-1:0] buf_rd_data, buf_wr_data, out_data;

  always #5 clk = ~clk;

  out_buf_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] wr_q[$];
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, valid_cnt = 0, hs_total = 0, done_cnt = 0;
  int outstanding = 0, max_out = 0, last_hs_cyc = 0;
  bit last_hs_seen = 0, hold_pending = 0;
  logic [DW-1:0] held_data = '0;
  bit cleared [256];

  // SRAM model: contents mem[a] = a until a word is cleared by a write.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= cleared[buf_rd_addr] ? '0 : DW'(buf_rd_addr);
    if (buf_wr_en) cleared[buf_wr_addr] <= (buf_wr_data == '0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, write or handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (buf_rd_en) begin
        rd_cnt++;
        outstanding++;
        if (addr_q.size() == 0) chk("rd_addr_unexpected", 64'(buf_rd_addr), 64'hdead);
        else chk("rd_addr", 64'(buf_rd_addr), 64'(addr_q.pop_front()));
      end
      if (buf_wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_addr_unexpected", 64'(buf_wr_addr), 64'hdead);
        else chk("wr_addr", 64'(buf_wr_addr), 64'(wr_q.pop_front()));
      end
      if (out_valid) valid_cnt++;
      if (hold_pending) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(held_data));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        hs_total++;
        outstanding--;
        if (exp_q.size() == 0) chk("out_unexpected", 64'(out_data), 64'hdead);
        else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
        if (out_last) begin last_hs_cyc = cyc; last_hs_seen = 1; end
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        done_cnt++;
        if (last_hs_seen) chk("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        last_hs_seen = 0;
      end
    end else begin
      hold_pending = 0;
    end
  end

  task automatic run(input logic [AW-1:0] base, input int n, input bit chk_lat,
                     input bit toggle, input bit poke, input bit hold_start,
                     input bit exp_zero, output int lat, output int bcyc);
    int t0;
    bit got;
    logic [AW-1:0] a;
    got = 0; lat = -1; bcyc = 0;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(exp_zero ? 32'd0 : 32'(a)), (i == n - 1)});
      addr_q.push_back(a);
`ifdef OUT_BUF_CLEAR_EN
      wr_q.push_back(a);
`endif
      a = a + 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; len = (AW+1)'(n);
    @(posedge clk); #1;
    t0 = cyc;
    if (hold_start) begin base_addr = 8'h55; len = 9'd3; end
    else start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (chk_lat && k == 0) begin
        chk("lat_first_rd_en", 64'(buf_rd_en), 64'd1);
        chk("lat_no_valid_yet", 64'(out_valid), 64'd0);
      end
      if (chk_lat && k == 1) chk("lat_first_valid", 64'(out_valid), 64'd1);
      if (busy) bcyc++;
      if (done) begin got = 1; lat = cyc - t0; break; end
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      if (poke && k == 1) begin start = 1'b1; base_addr = 8'h80; len = 9'd5; end
      if (poke && k == 2) start = 1'b0;
    end
    if (hold_start) begin @(posedge clk); #1; start = 1'b0; end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat, bc, rc0, vc0, dc0, h0;
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(buf_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(buf_rd_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // base 0x10, len 4, full throughput; a second start mid-drain must be ignored
    run(8'h10, 4, 1, 0, 1, 0, 0, lat, bc);
    chk("t1_start_to_done", 64'(lat), 64'd5);
    chk("t1_busy_cycles", 64'(bc), 64'd6);

    // address wrap FE, FF, 00, 01
    run(8'hFE, 4, 1, 0, 0, 0, 0, lat, bc);
    chk("t2_start_to_done", 64'(lat), 64'd5);

    // len 8 with out_ready toggling every cycle
    max_out = 0;
    rc0 = rd_cnt;
    run(8'h20, 8, 0, 1, 0, 0, 0, lat, bc);
    chk("t3_reads", 64'(rd_cnt - rc0), 64'd8);
    chk("t3_max_outstanding_le2", 64'(max_out <= 2), 64'd1);
    chk("t3_throttled", 64'(lat > 9), 64'd1);

    // len 0: one busy cycle, done pulse, no reads or output; start held into DONE is ignored
    rc0 = rd_cnt; vc0 = valid_cnt; dc0 = done_cnt;
    run(8'h30, 0, 0, 0, 0, 1, 0, lat, bc);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_start_to_done", 64'(lat), 64'd0);
    chk("t4_busy_cycles", 64'(bc), 64'd1);
    chk("t4_no_reads", 64'(rd_cnt - rc0), 64'd0);
    chk("t4_no_valid", 64'(valid_cnt - vc0), 64'd0);
    chk("t4_one_done", 64'(done_cnt - dc0), 64'd1);

    // async reset at word 3 of 8, then a clean restart
    h0 = hs_total;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h00; len = 9'd8;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'(i), (i == 7)});
      addr_q.push_back(8'(i));
`ifdef OUT_BUF_CLEAR_EN
      wr_q.push_back(8'(i));
`endif
    end
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 100 && hs_total < h0 + 3; k++) @(posedge clk);
    chk("t5_reached_word3", 64'(hs_total >= h0 + 3), 64'd1);
    @(negedge clk); #2;
    dc0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_rd_en", 64'(buf_rd_en), 64'd0);
    chk("t5_rst_last", 64'(out_last), 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    chk("t5_rst_rd_addr", 64'(buf_rd_addr), 64'd0);
    exp_q.delete(); addr_q.delete(); wr_q.delete();
    outstanding = 0; last_hs_seen = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    chk("t5_no_done", 64'(done_cnt - dc0), 64'd0);
    run(8'h40, 2, 1, 0, 0, 0, 0, lat, bc);
    chk("t5_restart_done", 64'(lat), 64'd3);

`ifdef OUT_BUF_CLEAR_EN
    // clear-on-read: the reread of the same words returns zero
    run(8'h60, 4, 0, 0, 0, 0, 0, lat, bc);
    run(8'h60, 4, 0, 0, 1, 0, 1, lat, bc);
    chk("t6_wr_q_drained", 64'(wr_q.size()), 64'd0);
`else
    chk("no_clear_writes", 64'(wr_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
